// File: rtl/zeroriscy_defines.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operator encoding, iteration count and FSM state encoding.
package zeroriscy_defines;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    ITER   = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } md_state_e;

  function automatic logic md_is_mult(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/zeroriscy_multdiv_iter_if.sv
// Request/result bundle between the ID/EX control and the multdiv unit.
interface zeroriscy_multdiv_iter_if;
  import zeroriscy_defines::*;

  logic        mult_en_i;
  logic        div_en_i;
  md_op_e      operator_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [31:0] multdiv_result_o;
  logic        ready_o;

  modport master (
    output mult_en_i, div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    input  multdiv_result_o, ready_o
  );

  modport slave (
    input  mult_en_i, div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
    output multdiv_result_o, ready_o
  );

endinterface

// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative RV32M multiply/divide unit. Borrows the ALU's 33-bit adder every
// active cycle and finishes one operation in a fixed 37 cycles.
module zeroriscy_multdiv_iter
  import zeroriscy_defines::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  zeroriscy_multdiv_iter_if.slave md,
  input  logic [33:0]             alu_adder_ext_i,
  output logic [32:0]             alu_operand_a_o,
  output logic [32:0]             alu_operand_b_o,
  output logic                    alu_en_o
);

  md_state_e   state_r;
  md_op_e      op_r;
  logic        neg_a_r;
  logic        neg_b_r;
  logic        carry_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] result_r;
  logic [4:0]  cnt_r;
  logic        alu_en_r;
  logic        ready_r;

  logic [31:0] sum_s;
  logic        carry_s;
  logic        adder_unused_s;
  logic        is_mult_s;
  logic        neg_res_s;
  logic [31:0] t_s;
  logic        success_s;
  logic [31:0] fix_lo_s;
  logic        abort_s;
  logic [32:0] opa_s;
  logic [32:0] opb_s;

  assign sum_s          = alu_adder_ext_i[32:1];
  assign carry_s        = alu_adder_ext_i[33];
  assign adder_unused_s = alu_adder_ext_i[0];
  assign is_mult_s      = md_is_mult(op_r);
  // Divider: R is held in hi_r, Q in lo_r; R[31] set means T already exceeds |B|
  assign t_s            = {hi_r[30:0], lo_r[31]};
  assign success_s      = hi_r[31] | carry_s;
  assign fix_lo_s       = (op_r == MD_OP_REM) ? hi_r : lo_r;
  assign abort_s        = !(md.mult_en_i | md.div_en_i) &&
                          (state_r != IDLE) && (state_r != DONE);

  // Sign of the final result for the latched operator
  always_comb begin
    neg_res_s = 1'b0;
    case (op_r)
      MD_OP_MULL, MD_OP_MULH: neg_res_s = neg_a_r ^ neg_b_r;
      MD_OP_DIV:              neg_res_s = (neg_a_r ^ neg_b_r) & (b_r != 32'd0);
      MD_OP_REM:              neg_res_s = neg_a_r;
      default:                neg_res_s = 1'b0;
    endcase
  end

  // Adder operand selection; idle and done states leave the adder at zero
  always_comb begin
    opa_s = 33'd0;
    opb_s = 33'd0;
    case (state_r)
      NEG_A: begin
        if (neg_a_r) begin
          opa_s = {~a_r, 1'b1};
          opb_s = {32'd0, 1'b1};
        end else begin
          opa_s = {a_r, 1'b0};
          opb_s = 33'd0;
        end
      end
      NEG_B: begin
        if (neg_b_r) begin
          opa_s = {~b_r, 1'b1};
          opb_s = {32'd0, 1'b1};
        end else begin
          opa_s = {b_r, 1'b0};
          opb_s = 33'd0;
        end
      end
      ITER: begin
        if (is_mult_s) begin
          opa_s = {hi_r, 1'b0};
          opb_s = lo_r[0] ? {a_r, 1'b0} : 33'd0;
        end else begin
          opa_s = {t_s, 1'b1};
          opb_s = {~b_r, 1'b1};
        end
      end
      FIX_LO: begin
        if (neg_res_s) begin
          opa_s = {~fix_lo_s, 1'b1};
          opb_s = {32'd0, 1'b1};
        end else begin
          opa_s = {fix_lo_s, 1'b0};
          opb_s = 33'd0;
        end
      end
      FIX_HI: begin
        // High word takes the carry out of the low-word negation
        if ((op_r == MD_OP_MULH) && neg_res_s) begin
          opa_s = {~hi_r, 1'b1};
          opb_s = {32'd0, carry_r};
        end else begin
          opa_s = {hi_r, 1'b0};
          opb_s = 33'd0;
        end
      end
      default: begin
        opa_s = 33'd0;
        opb_s = 33'd0;
      end
    endcase
  end

  // Control FSM together with the operand, shift and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= MD_OP_MULL;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      carry_r  <= 1'b0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      result_r <= 32'd0;
      cnt_r    <= 5'd0;
      alu_en_r <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      if (abort_s) begin
        state_r  <= IDLE;
        alu_en_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (md.mult_en_i | md.div_en_i) begin
              op_r     <= md.operator_i;
              neg_a_r  <= md.signed_mode_i[0] & md.op_a_i[31];
              neg_b_r  <= md.signed_mode_i[1] & md.op_b_i[31];
              a_r      <= md.op_a_i;
              b_r      <= md.op_b_i;
              alu_en_r <= 1'b1;
              state_r  <= NEG_A;
            end else begin
              alu_en_r <= 1'b0;
            end
          end
          NEG_A: begin
            a_r     <= sum_s;
            state_r <= NEG_B;
          end
          NEG_B: begin
            b_r     <= sum_s;
            hi_r    <= 32'd0;
            lo_r    <= is_mult_s ? sum_s : a_r;
            cnt_r   <= 5'(MD_ITERS - 1);
            state_r <= ITER;
          end
          ITER: begin
            if (is_mult_s) begin
              hi_r <= {carry_s, sum_s[31:1]};
              lo_r <= {sum_s[0], lo_r[31:1]};
            end else begin
              hi_r <= success_s ? sum_s : t_s;
              lo_r <= {lo_r[30:0], success_s};
            end
            cnt_r <= cnt_r - 5'd1;
            if (cnt_r == 5'd0) begin
              state_r <= FIX_LO;
            end
          end
          FIX_LO: begin
            lo_r    <= sum_s;
            carry_r <= carry_s;
            state_r <= FIX_HI;
          end
          FIX_HI: begin
            result_r <= (op_r == MD_OP_MULH) ? sum_s : lo_r;
            ready_r  <= 1'b1;
            alu_en_r <= 1'b0;
            state_r  <= DONE;
          end
          DONE: begin
            state_r <= IDLE;
          end
          default: begin
            alu_en_r <= 1'b0;
            state_r  <= IDLE;
          end
        endcase
      end
    end
  end

  assign alu_operand_a_o     = opa_s;
  assign alu_operand_b_o     = opb_s;
  assign alu_en_o            = alu_en_r;
  assign md.multdiv_result_o = result_r;
  assign md.ready_o          = ready_r;

endmodule

// File: doc/zeroriscy_multdiv_iter.md
Name: zeroriscy_multdiv_iter

Overview:
Iterative multiply/divide unit for RV32M, in the EX stage next to the ALU. It owns no adder of its own. Every cycle it drives the ALU's shared 33-bit adder through the multdiv operand inputs and consumes the 34-bit extended adder result on the next state update. It executes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at a time with a fixed 37-cycle latency. The ID stage stalls on it until ready_o.

Parameters:
MD_ITERS, 32, number of shift-add / shift-subtract iterations (equals datapath width; not intended to change)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mult_en_i  in  1  multiply request, held until ready_o
div_en_i  in  1  divide request, held until ready_o
operator_i  in  2  md_op_e: MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3
signed_mode_i  in  2  bit0 operand A signed, bit1 operand B signed
op_a_i  in  32  rs1 value
op_b_i  in  32  rs2 value
alu_adder_ext_i  in  34  ALU extended adder result; sum = [32:1], carry-out = [33]
alu_operand_a_o  out  33  {data32, cin_a} to ALU multdiv operand A
alu_operand_b_o  out  33  {data32, cin_b} to ALU multdiv operand B
alu_en_o  out  1  selects multdiv operands in the ALU adder
multdiv_result_o  out  32  result, valid when ready_o
ready_o  out  1  one-cycle done pulse

Behaviour:
- Reset state: IDLE. All registers are 0. alu_en_o=0, ready_o=0, multdiv_result_o=0, alu operands=0.
- Adder encodings:
  - ADD: a={X,0}, b={Y,0}
  - SUB X-Y: a={X,1}, b={~Y,1}; carry=1 means no borrow
  - NEG X with carry-in c: a={~X,1}, b={32'b0,c}
- Start: in IDLE with (mult_en_i|div_en_i)=1, latch operator, signed flags, op_a, op_b. Go to NEG_A.
- neg_a = signed_mode[0]&a[31]; neg_b = signed_mode[1]&b[31].
- States (one cycle each unless noted): IDLE -> NEG_A -> NEG_B -> ITER (MD_ITERS cycles, 5-bit down-counter) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
- NEG_A / NEG_B: replace the operand with its magnitude. If negation is needed, use NEG with c=1; otherwise ADD with 0 so the adder is always used. The result is stored as a 32-bit unsigned magnitude, so 0x80000000 stays 0x80000000.
- ITER, multiply: H=0 and L=|B| at entry.
  - Adder computes H + (L[0] ? |A| : 0).
  - Then {H,L} <= {carry, sum, L[31:1]}.
- ITER, divide: R=0 and Q=|A| at entry. T={R[30:0],Q[31]}.
  - Adder computes T - |B|.
  - Success when R[31]|carry: R<=sum. Otherwise R<=T.
  - Q <= {Q[30:0], success}.
- Result sign:
  - Multiply: neg_res = neg_a^neg_b.
  - Divide quotient: neg_res = neg_a^neg_b and |B|!=0.
  - Remainder: neg_res = neg_a.
- FIX_LO: conditionally negate the low word (L, Q or R) with c=1. Capture the carry.
- FIX_HI: conditionally negate H with c equal to the FIX_LO carry (MULH only; no-op ADD for other ops). Register the selected word:
  - MULL: low
  - MULH: high
  - DIV: Q
  - REM: R
- DONE: ready_o=1 for exactly this cycle. multdiv_result_o holds the value until the next FIX_HI.
- alu_en_o=1 in NEG_A through FIX_HI. It is 0 in IDLE and DONE.
- Divide by zero needs no special case: the quotient is 0xFFFFFFFF and the remainder is the dividend. Overflow 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
- Abort: if both enables are low in any state other than IDLE/DONE, go to IDLE next cycle. ready_o is not asserted and the result register is unchanged.
- Async reset asserted mid-operation: immediately IDLE, all outputs 0.
- Latency: request accepted at cycle 0, ready_o at cycle 37. Back-to-back: a new request is accepted in the cycle after DONE.

Decomposition:
- Shared package (zeroriscy_defines): md_op_e encoding, the MD_ITERS constant, and the md_state_e enum (IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE).
- No sub-module. The block is one FSM plus the H/L (Q/R) shift registers.
- Top-level wiring: alu_operand_*_o go to the ALU multdiv operand inputs, alu_en_o goes to the ALU multdiv enable, and the ALU extended adder output returns on alu_adder_ext_i.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULL of the same operands -> 0x00000001. ready_o exactly 37 cycles after accept.
- MULH signed -2 x 3 -> 0xFFFFFFFF. MULL -> 0xFFFFFFFA. MULHSU 0xFFFFFFFF(signed) x 0xFFFFFFFF(unsigned) -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF. REM -5 / 0 -> 0xFFFFFFFB. DIVU 0 / 0 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Drop div_en_i at ITER cycle 10 -> IDLE next cycle, no ready_o, result unchanged. Pulse rst_n low mid-ITER -> all outputs 0 immediately. Then a fresh MUL 3 x 4 -> 12.
